// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the five-stage RV32 pipeline.
package rv_pipe_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0 -- the canonical RISC-V NOP.
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IF/ID pipeline register contents as seen by decode.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  // A fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_word_t;

  localparam if_id_t IF_ID_RESET = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold or flush. A flush (also used for
// bubbles) clears valid and forces a NOP while keeping the last PC.
module if_id_reg
  import rv_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  if_id_t if_id_q, if_id_d;

  // Next-state select: flush beats load, otherwise hold.
  always_comb begin
    // NOTE: assigning the hold value first means every path writes if_id_d,
    // so no latch is inferred even when neither control is active.
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end else if (load_i) begin
      if_id_d = '{valid: 1'b1, pc: pc_i, instr: instr_i};
    end
  end

  // Register update with synchronous reset to an invalid NOP at PC 0.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) if_id_q <= IF_ID_RESET;
    else     if_id_q <= if_id_d;
  end

  assign valid_o = if_id_q.valid;
  assign pc_o    = if_id_q.pc;
  assign instr_o = if_id_q.instr;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, synchronous-read imem interface,
// one-entry skid buffer for responses that land during a stall, redirect
// handling, and the IF/ID register feeding decode.
module if_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = rv_pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
  output logic [XLEN-1:0] if_id_instr_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            buf_valid_q, buf_valid_d;
  fetch_word_t     buf_word_q, buf_word_d;

  logic            ifid_load, ifid_flush;
  logic [XLEN-1:0] ifid_pc, ifid_instr;

  // Targets are word aligned; the two low bits of a redirect are dropped.
  logic redirect_lsb_unused;
  assign redirect_lsb_unused = ^redirect_pc_i[1:0];

  assign imem_req_o  = en & ~rst & ~redirect_i & ~stall_i;
  assign imem_addr_o = pc_q;

  // Fetch control: redirect beats stall beats advance; en=0 freezes all.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    buf_valid_d   = buf_valid_q;
    buf_word_d    = buf_word_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_pc       = inflight_pc_q;
    ifid_instr    = imem_rdata_i;
    if (en) begin
      if (redirect_i) begin
        pc_d        = {redirect_pc_i[XLEN-1:2], 2'b00};
        inflight_d  = 1'b0;
        buf_valid_d = 1'b0;
        ifid_flush  = 1'b1;
      end else if (stall_i) begin
        // Park the response so it is not lost while IF/ID holds.
        inflight_d = 1'b0;
        if (inflight_q) begin
          buf_word_d  = '{pc: inflight_pc_q, instr: imem_rdata_i};
          buf_valid_d = 1'b1;
        end
      end else begin
        pc_d          = pc_q + XLEN'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        if (buf_valid_q) begin
          ifid_load   = 1'b1;
          ifid_pc     = buf_word_q.pc;
          ifid_instr  = buf_word_q.instr;
          buf_valid_d = 1'b0;
        end else if (inflight_q) begin
          ifid_load = 1'b1;
        end else begin
          ifid_flush = 1'b1;
        end
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Payload state, qualified by inflight_q / buf_valid_q.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are left unreset; their valid flags gate every use.
    inflight_pc_q <= inflight_pc_d;
    buf_word_q    <= buf_word_d;
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (ifid_pc),
    .instr_i (ifid_instr),
    .valid_o (if_id_valid_o),
    .pc_o    (if_id_pc_o),
    .instr_o (if_id_instr_o)
  );

  assign if_id_pc4_o = if_id_pc_o + XLEN'(4);

  // A stall clears inflight while filling the buffer, so both can never hold data.
  a_buf_inflight_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(buf_valid_q && inflight_q)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (RESET_PC 0 and 0xFFFF_FFF8) share
// stimulus; instance A is followed by a fetch-order scoreboard.
module tb_if_stage;
  import rv_pipe_pkg::*;

  localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk, rst, en, stall, redirect;
  logic [31:0] redirect_pc;

  logic        a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_rdata, a_pc, a_pc4, a_instr;
  logic [31:0] b_addr, b_rdata, b_pc, b_pc4, b_instr;

  if_stage u_dut_a (
    .clk(clk), .rst(rst), .en(en), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(a_req), .imem_addr_o(a_addr),
    .imem_rdata_i(a_rdata), .if_id_valid_o(a_valid), .if_id_pc_o(a_pc),
    .if_id_pc4_o(a_pc4), .if_id_instr_o(a_instr)
  );

  if_stage #(.RESET_PC(RESET_PC_B)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(b_req), .imem_addr_o(b_addr),
    .imem_rdata_i(b_rdata), .if_id_valid_o(b_valid), .if_id_pc_o(b_pc),
    .if_id_pc4_o(b_pc4), .if_id_instr_o(b_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word i holds 0x1000 + i.
  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return 32'h0000_1000 + (addr >> 2);
  endfunction

  // Synchronous-read imem models; rdata holds while no request is made.
  always @(posedge clk) if (a_req) a_rdata <= imem_word(a_addr);
  always @(posedge clk) if (b_req) b_rdata <= imem_word(b_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic expect_a(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, "_valid"}, 32'(a_valid), 32'd1);
    check({tag, "_pc"}, a_pc, pc);
    check({tag, "_instr"}, a_instr, ins);
  endtask

  task automatic expect_b(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] pc4);
    check({tag, "_valid"}, 32'(b_valid), 32'd1);
    check({tag, "_pc"}, b_pc, pc);
    check({tag, "_instr"}, b_instr, ins);
    check({tag, "_pc4"}, b_pc4, pc4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for instance A: a word is expected when its request is
  // issued; redirect and reset discard everything not yet in IF/ID.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        sb_e;
  logic [31:0] model_pc = 32'h0;
  bit          adv_prev = 1'b0;

  always @(posedge clk) begin
    adv_prev = en && !stall && !redirect && !rst;
    if (rst) begin
      exp_q.delete();
      model_pc = 32'h0;
    end else if (en) begin
      if (redirect) begin
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
        exp_q.push_back('{pc: model_pc, instr: imem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Every newly loaded valid IF/ID entry must be the oldest expected word.
  always @(negedge clk) begin
    if (adv_prev && a_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(a_valid), 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_pc", a_pc, sb_e.pc);
        check("sb_instr", a_instr, sb_e.instr);
        check("sb_pc4", a_pc4, sb_e.pc + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_instr", a_instr, NOP);
    check("rst_pc", a_pc, 32'h0);
    check("rst_pc4", a_pc4, 32'h4);
    check("rst_req", 32'(a_req), 32'd0);
    check("rst_addr_b", b_addr, RESET_PC_B);

    // 1. Reset release and streaming
    rst = 1'b0;
    #1;
    check("first_req", 32'(a_req), 32'd1);
    check("first_addr", a_addr, 32'h0);
    tick();
    check("lat1_valid", 32'(a_valid), 32'd0);
    tick();
    expect_a("lat2", 32'h0, 32'h1000);
    check("lat2_pc4", a_pc4, 32'h4);
    tick();
    expect_a("seq1", 32'h4, 32'h1001);

    // 2. Three-cycle stall while pc=8 is in flight
    stall = 1'b1;
    #1;
    check("stall_req", 32'(a_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_a("stall_hold", 32'h4, 32'h1001);
    end
    stall = 1'b0;
    tick();
    expect_a("stall_rel1", 32'h8, 32'h1002);
    tick();
    expect_a("stall_rel2", 32'hC, 32'h1003);

    // 3. Redirect while streaming
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    check("redir_req", 32'(a_req), 32'd0);
    tick();
    check("redir_flush_valid", 32'(a_valid), 32'd0);
    check("redir_flush_instr", a_instr, NOP);
    check("redir_addr", a_addr, 32'h40);
    redirect = 1'b0;
    tick();
    check("redir_gap_valid", 32'(a_valid), 32'd0);
    tick();
    expect_a("redir_target", 32'h40, 32'h1010);

    // 4. Redirect plus stall with the skid buffer full, misaligned target
    stall = 1'b1;
    tick();
    expect_a("buf_fill_hold", 32'h40, 32'h1010);
    redirect = 1'b1; redirect_pc = 32'h42;
    #1;
    check("rs_req", 32'(a_req), 32'd0);
    tick();
    check("rs_flush_valid", 32'(a_valid), 32'd0);
    check("rs_flush_instr", a_instr, NOP);
    check("rs_align_addr", a_addr, 32'h40);
    stall = 1'b0; redirect = 1'b0;
    tick();
    tick();
    expect_a("rs_target", 32'h40, 32'h1010);
    tick();
    expect_a("rs_next", 32'h44, 32'h1011);

    // 5. Freeze for five cycles
    en = 1'b0;
    #1;
    check("frz_req", 32'(a_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_a("frz_hold", 32'h44, 32'h1011);
      check("frz_addr", a_addr, 32'h4C);
      check("frz_req_hold", 32'(a_req), 32'd0);
    end
    en = 1'b1;
    tick();
    expect_a("frz_resume1", 32'h48, 32'h1012);
    tick();
    expect_a("frz_resume2", 32'h4C, 32'h1013);

    // 6. Mid-stream reset, then wrap-around on instance B
    rst = 1'b1;
    tick();
    check("mrst_valid", 32'(a_valid), 32'd0);
    check("mrst_instr", a_instr, NOP);
    check("mrst_pc", a_pc, 32'h0);
    check("mrst_pc4", a_pc4, 32'h4);
    check("mrst_addr", a_addr, 32'h0);
    check("mrst_valid_b", 32'(b_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst_lat1_b", 32'(b_valid), 32'd0);
    tick();
    expect_b("wrap0", 32'hFFFF_FFF8, 32'h4000_0FFE, 32'hFFFF_FFFC);
    expect_a("mrst_first_a", 32'h0, 32'h1000);
    tick();
    expect_b("wrap1", 32'hFFFF_FFFC, 32'h4000_0FFF, 32'h0);
    tick();
    expect_b("wrap2", 32'h0, 32'h1000, 32'h4);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage pipeline. It sits directly upstream of decode inside MAIN.
- It owns the PC register and drives a synchronous-read instruction memory (one-cycle read latency).
- It absorbs hazard stalls without losing in-flight responses, handles EX-stage branch/jump redirects, and presents the IF/ID pipeline register to decode.

Parameters:
- XLEN, 32, data and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global run enable; when 0, all state is frozen.
- stall_i  in  1  hazard-unit stall; holds PC and IF/ID.
- redirect_i  in  1  taken branch/jump resolved in EX.
- redirect_pc_i  in  XLEN  redirect target (byte address).
- imem_req_o  out  1  read request this cycle.
- imem_addr_o  out  XLEN  byte address of the request (equals pc_q).
- imem_rdata_i  in  XLEN  instruction word, valid the cycle after a request.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_pc_o  out  XLEN  PC of the IF/ID instruction.
- if_id_pc4_o  out  XLEN  if_id_pc_o + 4, mod 2^XLEN.
- if_id_instr_o  out  XLEN  instruction; NOP when invalid.

Behaviour:
- Reset (rst=1 at an edge, overrides everything including en=0):
  - pc_q=RESET_PC, inflight_q=0, buf_valid_q=0.
  - if_id_valid_o=0, if_id_instr_o=32'h0000_0013 (NOP), if_id_pc_o=0, if_id_pc4_o=4.
  - imem_req_o is combinational and is 0 while rst=1.
- Request: imem_req_o = en & ~rst & ~redirect_i & ~stall_i; imem_addr_o = pc_q always.
  - On a request edge: pc_q <= pc_q+4 (wraps 32'hFFFF_FFFC -> 0), inflight_q <= 1, inflight_pc_q <= pc_q.
  - Otherwise inflight_q <= 0 (except when frozen by en=0).
- Advance (en & ~stall_i & ~redirect_i):
  - If buf_valid_q: IF/ID <= {1, buf_pc, buf_instr}, and buf_valid_q <= 0.
  - Else if inflight_q: IF/ID <= {1, inflight_pc_q, imem_rdata_i}.
  - Else: IF/ID <= bubble (valid=0, instr=NOP, pc unchanged).
- Stall (en & stall_i & ~redirect_i):
  - IF/ID and pc_q hold.
  - If inflight_q, the response is captured: buf <= {inflight_pc_q, imem_rdata_i}, buf_valid_q <= 1.
  - No new request, so buf and inflight are never both occupied. This invariant is an assertion.
- Redirect (en & redirect_i), wins over stall_i:
  - pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00}; misaligned low bits are dropped.
  - inflight_q <= 0; the pending response is discarded. buf_valid_q <= 0.
  - IF/ID flushed: valid=0, instr=NOP.
  - The first request to the target issues the following cycle.
- en=0: every register holds, including buf and inflight. The response arriving during the freeze is not captured.
  - The imem model is required to hold rdata while req=0, so the response is consumed on resume.
  - redirect_i is ignored; upstream holds it until en=1.
- Latency: first valid IF/ID two cycles after rst deasserts. Throughput is one instruction per cycle with no stalls.
- Redirect to the first target instruction in IF/ID: two cycles.
- No instruction is ever duplicated or dropped across any stall length.
- Reset mid-stream: the next cycle behaves exactly as after power-on reset; in-flight and buffered words are discarded.

Decomposition:
- Shared package rv_pipe_pkg:
  - XLEN.
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default.
  - Struct/field widths for the IF/ID bundle {valid, pc, instr}.
- One sub-module, if_id_reg: IF/ID register with load/hold/flush controls and NOP on flush/reset.
- PC, inflight and skid buffer logic stays in if_stage.

Test Plan:
1. Reset release, imem[i]=0x1000+i, no stalls -> first valid at cycle 2 with pc=0, instr=0x1000. Then pc=4/0x1001, pc=8/0x1002 on consecutive cycles; pc4=pc+4.
2. stall_i=1 for 3 cycles while pc=8 is in flight -> IF/ID holds pc=4 for the stall duration. On release, pc=8/0x1002 appears, then pc=12. No gap beyond one bubble, no duplicate.
3. redirect_i=1, redirect_pc_i=0x40 while streaming -> next cycle IF/ID valid=0, instr=0x13. Two cycles after redirect, IF/ID holds pc=0x40/0x1010. The discarded in-flight word never appears.
4. redirect_i and stall_i together with buf_valid=1 -> buffer dropped, flush, pc_q=0x40. redirect_pc_i=0x42 -> fetch at 0x40.
5. en=0 for 5 cycles mid-stream -> imem_req_o=0, all outputs constant. On en=1, the sequence resumes at the exact next PC with no loss.
6. RESET_PC=32'hFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc4 of 0xFFFF_FFFC = 0. Assert rst mid-stream -> outputs return to reset values the following cycle.
